// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO register owner for the MIPS core: sequences the external iterative divider,
// computes MULT/MULTU internally and executes MTHI/MTLO beside the EX stage.
module muldiv_hilo_ctrl #(
   parameter int ACK_WAIT       = 4,
   parameter int DIV_CYCLES_MAX = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        op_ready,
   input  logic        flush,
   input  logic        rd_req,
   input  logic        rd_sel,
   output logic [31:0] rd_data,
   output logic        stall,
   output logic        err,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_busy,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r
);

   localparam int ACK_W = $clog2(ACK_WAIT + 1);
   localparam int RUN_W = $clog2(DIV_CYCLES_MAX + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_WAIT - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DIV_CYCLES_MAX - 1);

   localparam logic [2:0] OP_DIV   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd3;
   localparam logic [2:0] OP_MTLO  = 3'd4;

   typedef enum logic [2:0] {
      IDLE,
      DIV_REQ,
      DIV_RUN,
      DIV_DRAIN,
      MUL,
      WB
   } state_t;

   state_t            state_reg, state_next;
   logic [31:0]       hi_reg, hi_next;
   logic [31:0]       lo_reg, lo_next;
   logic [31:0]       opa_reg, opa_next;
   logic [31:0]       opb_reg, opb_next;
   logic              mul_signed_reg, mul_signed_next;
   logic              err_reg, err_next;
   logic [ACK_W-1:0]  ack_cnt_reg, ack_cnt_next;
   logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;

   logic [63:0]       mul_a_ext;
   logic [63:0]       mul_b_ext;
   logic [63:0]       mul_prod;

   // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact for both.
   assign mul_a_ext = {{32{mul_signed_reg & opa_reg[31]}}, opa_reg};
   assign mul_b_ext = {{32{mul_signed_reg & opb_reg[31]}}, opb_reg};
   assign mul_prod  = mul_a_ext * mul_b_ext;

   always_comb begin
      state_next      = state_reg;
      hi_next         = hi_reg;
      lo_next         = lo_reg;
      opa_next        = opa_reg;
      opb_next        = opb_reg;
      mul_signed_next = mul_signed_reg;
      err_next        = err_reg;
      ack_cnt_next    = ack_cnt_reg;
      run_cnt_next    = run_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (op_valid && !flush) begin
               case (op)
                  OP_DIV: begin
                     if (rt_val == 32'd0) begin
                        lo_next = 32'hFFFF_FFFF;
                        hi_next = rs_val;
                     end else begin
                        opa_next     = rs_val;
                        opb_next     = rt_val;
                        ack_cnt_next = '0;
                        state_next   = DIV_REQ;
                     end
                  end
                  OP_MULT, OP_MULTU: begin
                     opa_next        = rs_val;
                     opb_next        = rt_val;
                     mul_signed_next = (op == OP_MULT);
                     state_next      = MUL;
                  end
                  OP_MTHI: hi_next = rs_val;
                  OP_MTLO: lo_next = rs_val;
                  default: ;
               endcase
            end
         end

         DIV_REQ: begin
            if (flush) begin
               // A busy divider has already taken the start, so it must be drained.
               state_next = div_busy ? DIV_DRAIN : IDLE;
            end else if (div_busy) begin
               run_cnt_next = '0;
               state_next   = DIV_RUN;
            end else if (ack_cnt_reg == ACK_LAST) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               ack_cnt_next = ack_cnt_reg + 1'b1;
            end
         end

         DIV_RUN: begin
            if (flush) begin
               state_next = DIV_DRAIN;
            end else if (!div_busy) begin
               lo_next    = div_q;
               hi_next    = div_r;
               state_next = WB;
            end else if (run_cnt_reg == RUN_LAST) begin
               err_next   = 1'b1;
               state_next = DIV_DRAIN;
            end else begin
               run_cnt_next = run_cnt_reg + 1'b1;
            end
         end

         DIV_DRAIN: begin
            if (!div_busy) state_next = IDLE;
         end

         MUL: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               hi_next    = mul_prod[63:32];
               lo_next    = mul_prod[31:0];
               state_next = WB;
            end
         end

         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         hi_reg         <= '0;
         lo_reg         <= '0;
         opa_reg        <= '0;
         opb_reg        <= '0;
         mul_signed_reg <= 1'b0;
         err_reg        <= 1'b0;
         ack_cnt_reg    <= '0;
         run_cnt_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         hi_reg         <= hi_next;
         lo_reg         <= lo_next;
         opa_reg        <= opa_next;
         opb_reg        <= opb_next;
         mul_signed_reg <= mul_signed_next;
         err_reg        <= err_next;
         ack_cnt_reg    <= ack_cnt_next;
         run_cnt_reg    <= run_cnt_next;
      end
   end

   assign op_ready     = (state_reg == IDLE);
   assign stall        = (op_valid | rd_req) & ~op_ready;
   assign rd_data      = rd_sel ? hi_reg : lo_reg;
   assign hi           = hi_reg;
   assign lo           = lo_reg;
   assign err          = err_reg;
   assign div_start    = (state_reg == DIV_REQ) & ~flush;
   assign div_dividend = opa_reg;
   assign div_divisor  = opb_reg;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized self-checking bench for muldiv_hilo_ctrl: scripted divider, transaction-level
// HI/LO model, and a per-cycle comparison of every output against that model.
module tb_muldiv_hilo_ctrl;

   localparam int ACK_WAIT       = 4;
   localparam int DIV_CYCLES_MAX = 40;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        op_ready;
   logic        flush = 1'b0;
   logic        rd_req = 1'b0;
   logic        rd_sel = 1'b0;
   logic [31:0] rd_data;
   logic        stall;
   logic        err;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_start;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_busy = 1'b0;
   logic [31:0] div_q = '0;
   logic [31:0] div_r = '0;

   int checks   = 0;
   int failures = 0;

   // model of the architectural state
   logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
   logic        m_err = 1'b0, m_ready = 1'b1, m_start = 1'b0, m_hold = 1'b0;
   bit          rd_force = 1'b0;
   bit          noise_en = 1'b0;

   muldiv_hilo_ctrl #(.ACK_WAIT(ACK_WAIT), .DIV_CYCLES_MAX(DIV_CYCLES_MAX)) dut (
      .clock(clock), .reset(reset), .op_valid(op_valid), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .flush(flush),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall),
      .err(err), .hi(hi), .lo(lo), .div_start(div_start),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
   );

   always #5 clock = ~clock;

   function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void compare_outputs();
      chk32("hi", hi, m_hi);
      chk32("lo", lo, m_lo);
      chk32("rd_data", rd_data, rd_sel ? m_hi : m_lo);
      chk1("err", err, m_err);
      chk1("op_ready", op_ready, m_ready);
      chk1("stall", stall, (op_valid | rd_req) & ~m_ready);
      chk1("div_start", div_start, m_start & ~flush);
      if (m_hold) begin
         chk32("div_dividend", div_dividend, m_a);
         chk32("div_divisor", div_divisor, m_b);
      end
   endfunction

   // One clock: compare on the falling edge, then move past the rising edge and re-drive.
   task automatic step();
      @(negedge clock);
      compare_outputs();
      @(posedge clock);
      #1;
      if (rd_force) begin
         rd_req = 1'b1;
         rd_sel = 1'b1;
      end else begin
         rd_req = 1'($urandom % 2);
         rd_sel = 1'($urandom % 2);
      end
      if (noise_en) begin
         op_valid = (($urandom % 4) == 0);
         op       = 3'd7;
         rs_val   = $urandom;
         rt_val   = $urandom;
      end
   endtask

   // flush_run < 0: no flush during the run; flush_req: flush on the first request cycle.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int ack_dly,
                         input int run_len, input int flush_run, input bit flush_req);
      int          sa, sb, n, j;
      logic [31:0] q, r;
      bit          draining, busy_now, fl;
      sa = int'(a);
      sb = int'(b);
      op_valid = 1'b1; op = 3'd0; rs_val = a; rt_val = b;
      step();
      op_valid = 1'b0;
      $display("txn DIV a=%08h b=%08h ack=%0d run=%0d flush_run=%0d flush_req=%0b",
               a, b, ack_dly, run_len, flush_run, flush_req);
      if (b == 32'd0) begin
         m_lo = 32'hFFFF_FFFF;
         m_hi = a;
         return;
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      m_ready = 1'b0; m_start = 1'b1; m_hold = 1'b1; m_a = a; m_b = b;
      n = 0;
      forever begin
         if (flush_req) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            m_start = 1'b0; m_hold = 1'b0; m_ready = 1'b1;
            return;
         end
         div_busy = (n == ack_dly);
         step();
         if (div_busy) break;
         n++;
         if (n == ACK_WAIT) begin
            m_err = 1'b1; m_start = 1'b0; m_hold = 1'b0; m_ready = 1'b1;
            return;
         end
      end
      m_start = 1'b0;
      draining = 1'b0;
      j = 0;
      forever begin
         busy_now = (j < run_len);
         fl       = !draining && (flush_run == j);
         div_busy = busy_now;
         flush    = fl;
         div_q    = (busy_now || draining || fl) ? $urandom : q;
         div_r    = (busy_now || draining || fl) ? $urandom : r;
         step();
         flush = 1'b0;
         if (draining) begin
            if (!busy_now) begin
               m_ready = 1'b1; m_hold = 1'b0;
               return;
            end
         end else if (fl) begin
            draining = 1'b1;
         end else if (!busy_now) begin
            m_lo = q; m_hi = r; m_hold = 1'b0;
            step();
            m_ready = 1'b1;
            return;
         end else if (j == DIV_CYCLES_MAX - 1) begin
            m_err = 1'b1;
            draining = 1'b1;
         end
         j++;
      end
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit fl);
      longint          la, lb;
      longint unsigned ua, ub;
      logic [63:0]     prod;
      la = longint'(int'(a));
      lb = longint'(int'(b));
      ua = longint'(a);
      ub = longint'(b);
      prod = sgn ? 64'(la * lb) : 64'(ua * ub);
      op_valid = 1'b1; op = sgn ? 3'd1 : 3'd2; rs_val = a; rt_val = b;
      step();
      op_valid = 1'b0;
      m_ready = 1'b0;
      $display("txn %s a=%08h b=%08h flush=%0b", sgn ? "MULT" : "MULTU", a, b, fl);
      if (fl) begin
         flush = 1'b1;
         step();
         flush = 1'b0;
         m_ready = 1'b1;
         return;
      end
      step();
      m_hi = prod[63:32];
      m_lo = prod[31:0];
      step();
      m_ready = 1'b1;
   endtask

   task automatic do_mt(input bit to_hi, input logic [31:0] v);
      op_valid = 1'b1; op = to_hi ? 3'd3 : 3'd4; rs_val = v;
      step();
      op_valid = 1'b0;
      if (to_hi) m_hi = v; else m_lo = v;
      $display("txn %s v=%08h", to_hi ? "MTHI" : "MTLO", v);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      m_hi = '0; m_lo = '0; m_err = 1'b0; m_ready = 1'b1; m_start = 1'b0; m_hold = 1'b0;
      div_busy = 1'b0; flush = 1'b0; op_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      $display("txn RESET");
   endtask

   initial begin
      logic [31:0] a, b;
      int          k, run, fr;
      repeat (3) @(posedge clock);
      #1;
      chk32("reset_hi", hi, 32'h0);
      chk32("reset_lo", lo, 32'h0);
      chk1("reset_err", err, 1'b0);
      chk1("reset_div_start", div_start, 1'b0);
      reset = 1'b1;
      step();
      chk1("reset_op_ready", op_ready, 1'b1);

      do_div(32'd100, 32'd7, 2, 5, -1, 1'b0);
      chk32("div100_lo", lo, 32'd14);
      chk32("div100_hi", hi, 32'd2);
      chk1("div100_ready", op_ready, 1'b1);

      rd_force = 1'b1;
      do_div(32'hFFFF_FFF9, 32'd2, 1, 6, -1, 1'b0);
      rd_force = 1'b0;
      rd_sel = 1'b1;
      #1;
      chk32("divneg_rd", rd_data, 32'hFFFF_FFFF);
      chk32("divneg_lo", lo, 32'hFFFF_FFFD);

      do_div(32'h0000_1234, 32'd0, 0, 0, -1, 1'b0);
      chk32("div0_lo", lo, 32'hFFFF_FFFF);
      chk32("div0_hi", hi, 32'h0000_1234);

      do_mul(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
      chk32("mult_hi", hi, 32'hFFFF_FFFF);
      chk32("mult_lo", lo, 32'hFFFF_FFFA);
      do_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      chk32("multu_hi", hi, 32'h0000_0001);
      chk32("multu_lo", lo, 32'hFFFF_FFFE);

      op_valid = 1'b1; op = 3'd3; rs_val = 32'hA5A5_A5A5; rd_req = 1'b1; rd_sel = 1'b1;
      #1;
      chk32("mthi_old_rd", rd_data, 32'h0000_0001);
      step();
      op_valid = 1'b0;
      m_hi = 32'hA5A5_A5A5;
      chk32("mthi_new_hi", hi, 32'hA5A5_A5A5);
      $display("txn MTHI v=a5a5a5a5 with rd_req");

      do_div(32'd1000, 32'd9, 0, 8, 3, 1'b0);
      chk32("flushrun_hi", hi, 32'hA5A5_A5A5);
      chk32("flushrun_lo", lo, 32'hFFFF_FFFE);

      op_valid = 1'b1; op = 3'd4; rs_val = 32'h0BAD_F00D; flush = 1'b1;
      step();
      flush = 1'b0;
      chk32("flushidle_lo", lo, 32'hFFFF_FFFE);
      op_valid = 1'b1; op = 3'd4; rs_val = 32'h0BAD_F00D;
      step();
      op_valid = 1'b0;
      m_lo = 32'h0BAD_F00D;
      $display("txn MTLO flushed then accepted");

      do_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
      do_div(32'd77, 32'd5, 0, 4, -1, 1'b1);
      chk32("flushmisc_lo", lo, 32'h0BAD_F00D);

      noise_en = 1'b1;
      for (int t = 0; t < 150; t++) begin
         k = $urandom_range(0, 9);
         a = $urandom;
         b = ($urandom % 2) ? 32'($urandom_range(1, 50)) : $urandom;
         if (k <= 3) begin
            if ($urandom % 8 == 0) b = 32'd0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            if ($urandom % 2) a = 32'($urandom_range(0, 100000));
            run = $urandom_range(1, 12);
            fr  = ($urandom % 6 == 0) ? $urandom_range(0, run) : -1;
            do_div(a, b, ($urandom % 10 == 0) ? 4 : $urandom_range(0, 3), run, fr,
                   ($urandom % 12) == 0);
         end else if (k <= 6) begin
            do_mul(a, b, 1'($urandom % 2), ($urandom % 6) == 0);
         end else if (k <= 8) begin
            do_mt(1'($urandom % 2), a);
         end else begin
            op_valid = 1'b1; op = 3'($urandom_range(5, 7)); rs_val = a;
            step();
            op_valid = 1'b0;
            $display("txn NOP op=%0d", op);
         end
      end
      noise_en = 1'b0;

      do_reset();
      do_mt(1'b1, 32'h1357_9BDF);
      do_div(32'd500, 32'd4, 0, 45, -1, 1'b0);
      chk1("runtimeout_err", err, 1'b1);
      chk32("runtimeout_hi", hi, 32'h1357_9BDF);

      do_reset();
      do_mt(1'b0, 32'h2468_ACE0);
      op_valid = 1'b1; op = 3'd0; rs_val = 32'd50; rt_val = 32'd3; div_busy = 1'b0;
      step();
      op_valid = 1'b0;
      m_ready = 1'b0; m_start = 1'b1; m_hold = 1'b1; m_a = 32'd50; m_b = 32'd3;
      div_busy = 1'b1;
      step();
      m_start = 1'b0;
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      chk32("midrst_lo", lo, 32'h0);
      chk32("midrst_hi", hi, 32'h0);
      chk1("midrst_div_start", div_start, 1'b0);
      m_hi = '0; m_lo = '0; m_err = 1'b0; m_ready = 1'b1; m_hold = 1'b0;
      div_busy = 1'b0;
      step();
      reset = 1'b1;
      step();
      $display("txn RESET mid-DIV");

      do_mt(1'b1, 32'hCAFE_0001);
      do_div(32'd9, 32'd4, 4, 1, -1, 1'b0);
      chk1("acktimeout_err", err, 1'b1);
      chk32("acktimeout_hi", hi, 32'hCAFE_0001);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Owns the HI/LO architectural registers of the MIPS core.
- Sequences the external iterative signed divider (start/busy/q/r handshake) for DIV.
- Computes MULT/MULTU internally with a registered 2-cycle product; executes MTHI/MTLO.
- Sits beside the EX stage: asserts stall to the pipeline while a long operation is in flight and MFHI/MFLO or a new HI/LO op arrives.

Parameters:
- ACK_WAIT, 4: max cycles div_start is held waiting for div_busy=1 before error.
- DIV_CYCLES_MAX, 40: max cycles in DIV_RUN before error (divider nominally 32 iterations).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  HI/LO op request from EX.
- op  in  3  0=DIV, 1=MULT, 2=MULTU, 3=MTHI, 4=MTLO, others ignored (treated as no-op, accepted).
- rs_val  in  32  operand A / dividend / MTHI-MTLO source.
- rt_val  in  32  operand B / divisor.
- op_ready  out  1  high only in IDLE; op accepted on posedge when op_valid&op_ready.
- flush  in  1  cancel in-flight op; results discarded.
- rd_req  in  1  MFHI/MFLO in EX.
- rd_sel  in  1  0=LO, 1=HI.
- rd_data  out  32  selected register, combinational from registered HI/LO.
- stall  out  1  (op_valid|rd_req) & ~op_ready.
- err  out  1  sticky divider-handshake error; cleared only by reset.
- hi, lo  out  32  current HI/LO.
- div_start  out  1  divider start request.
- div_dividend, div_divisor  out  32  held stable from DIV_REQ until DIV_RUN exits.
- div_busy  in  1  divider busy.
- div_q, div_r  in  32  divider quotient/remainder, valid once div_busy falls.

Behaviour:
- Reset (reset=0, any state): hi=lo=0, state=IDLE, div_start=0, err=0, operand regs=0; op_ready=1 after release.
- States: IDLE, DIV_REQ, DIV_RUN, DIV_DRAIN, MUL, WB.
- IDLE: MTHI/MTLO write hi/lo at the accepting edge; stay IDLE. rd_req in the same cycle returns the old value.
- IDLE, DIV, rt_val!=0: latch operands -> DIV_REQ.
- IDLE, DIV, rt_val==0: no divider call; lo=32'hFFFFFFFF, hi=rs_val at the accepting edge; stay IDLE.
- IDLE, MULT/MULTU: latch operands and signedness -> MUL.
- DIV_REQ: div_start=1 each cycle.
  - div_busy sampled 1 -> DIV_RUN, div_start=0.
  - ACK_WAIT cycles without div_busy -> err=1, IDLE, hi/lo unchanged.
- DIV_RUN: count cycles.
  - div_busy sampled 0 -> capture lo=div_q, hi=div_r -> WB.
  - Count reaches DIV_CYCLES_MAX -> err=1 -> DIV_DRAIN.
- MUL: register 64-bit product (signed for MULT, zero-extended for MULTU) -> WB, writing hi=prod[63:32], lo=prod[31:0] at that edge.
- WB: one bubble cycle, op_ready=0 -> IDLE.
- Latency, accept edge to op_ready: MULT 2 cycles; DIV = ack cycles + divider run + 1.
- flush:
  - In DIV_REQ: drop div_start -> IDLE.
  - In DIV_RUN: the divider cannot abort, so -> DIV_DRAIN; wait for div_busy=0, discard q/r -> IDLE.
  - In MUL: discard product -> IDLE.
  - In IDLE: blocks acceptance that cycle.
  - flush has priority over completion in the same cycle (no hi/lo write).
- stall is combinational. A pending op stays presented by EX until accepted.

Test Plan:
- DIV rs=100, rt=7 -> div_start until busy, then lo=14, hi=2; stall high throughout, op_ready returns 1 after WB.
- DIV rs=-7 (FFFFFFF9), rt=2 -> lo=FFFFFFFD, hi=FFFFFFFF; rd_req rd_sel=1 during run -> stall=1, then rd_data=FFFFFFFF.
- DIV rt=0, rs=0x1234 -> no div_start pulse, lo=FFFFFFFF, hi=00001234 same edge.
- MULT FFFFFFFE*3 -> hi=FFFFFFFF, lo=FFFFFFFA after 2 cycles; MULTU FFFFFFFF*2 -> hi=00000001, lo=FFFFFFFE.
- MTHI 0xA5A5A5A5 with simultaneous rd_req rd_sel=1 -> rd_data=old hi that cycle, hi=A5A5A5A5 next cycle.
- flush in DIV_RUN -> DIV_DRAIN until busy=0, hi/lo unchanged. Reset low mid-DIV -> hi=lo=0, div_start=0 immediately. div_busy tied 0 -> err=1 after 4 cycles.
